// File: rtl/win_cmd_gen_pkg.sv
// Shared definitions for the window command generator: command bit indices,
// repeat-engine state encoding and the direction priority picker.
package win_cmd_gen_pkg;

    localparam int CMD_W   = 7;
    localparam int M_UP    = 0;
    localparam int M_DOWN  = 1;
    localparam int M_LEFT  = 2;
    localparam int M_RIGHT = 3;
    localparam int Z_IN    = 4;
    localparam int Z_OUT   = 5;
    localparam int M_MODE  = 6;

    typedef enum logic [1:0] {
        RPT_IDLE = 2'd0,
        RPT_DLY  = 2'd1,
        RPT_RPT  = 2'd2
    } rpt_state_e;

    // Simultaneous presses resolve up > down > left > right.
    function automatic logic [1:0] dir_pick(input logic [3:0] rise);
        logic [1:0] sel;
        if (rise[M_UP]) begin
            sel = 2'd0;
        end else if (rise[M_DOWN]) begin
            sel = 2'd1;
        end else if (rise[M_LEFT]) begin
            sel = 2'd2;
        end else begin
            sel = 2'd3;
        end
        return sel;
    endfunction

endpackage

// File: rtl/win_cmd_gen_btn_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer and rising-edge
// detector for one raw push-button.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic [1:0]       sync_q, sync_d;
    logic             level_q, level_d;
    logic             level_d1_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        sync_d  = {sync_q[0], raw};
        level_d = level_q;
        cnt_d   = {CNT_W{1'b0}};
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync_q[1];
                cnt_d   = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // Synchroniser, debounced level and its one-cycle delayed copy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q     <= 2'b00;
            level_q    <= 1'b0;
            level_d1_q <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
        end else begin
            sync_q     <= sync_d;
            level_q    <= level_d;
            level_d1_q <= level_q;
            cnt_q      <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = level_q & ~level_d1_q;

endmodule

// File: rtl/win_cmd_gen.sv
// Push-button to WIN_CTRL_CMD converter: debounced press pulses, single-owner
// direction auto-repeat, zoom pulses and the move-mode level.
module win_cmd_gen
    import win_cmd_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int CNT_W           = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_zin,
    input  logic             btn_zout,
    input  logic             btn_mode,
    input  logic             run,
    output logic [CMD_W-1:0] win_ctrl_cmd
);

    logic [3:0]       dir_raw_s, dir_lvl_s, dir_rise_s;
    logic             zin_rise_s, zout_rise_s, mode_rise_s;
    logic             opposite_s, start_s, owner_lvl_s;
    logic             zin_s, zout_s;
    logic [3:0]       dir_pulse_s;
    rpt_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       owner_q, owner_d;
    logic             mode_q, mode_d;
    logic [CMD_W-1:0] cmd_q, cmd_d;

    assign dir_raw_s = {btn_right, btn_left, btn_down, btn_up};

    for (genvar i = 0; i < 4; i++) begin : g_dir
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
            .clk(clk), .rst(rst), .raw(dir_raw_s[i]), .level(dir_lvl_s[i]), .rise(dir_rise_s[i])
        );
    end

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_zin (
        .clk(clk), .rst(rst), .raw(btn_zin), .level(), .rise(zin_rise_s)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_zout (
        .clk(clk), .rst(rst), .raw(btn_zout), .level(), .rise(zout_rise_s)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_mode (
        .clk(clk), .rst(rst), .raw(btn_mode), .level(), .rise(mode_rise_s)
    );

    // An opposing pair held together blocks any new direction from starting.
    assign opposite_s  = (dir_lvl_s[M_UP] & dir_lvl_s[M_DOWN]) |
                         (dir_lvl_s[M_LEFT] & dir_lvl_s[M_RIGHT]);
    assign start_s     = (|dir_rise_s) & ~opposite_s;
    assign owner_lvl_s = dir_lvl_s[owner_q];
    assign zin_s       = zin_rise_s & ~zout_rise_s;
    assign zout_s      = zout_rise_s & ~zin_rise_s;
    assign mode_d      = mode_q ^ mode_rise_s;

    // Repeat engine next state; losing the owner level wins over any pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RPT_IDLE: begin
                if (start_s) state_d = RPT_DLY;
                else         state_d = RPT_IDLE;
            end
            RPT_DLY: begin
                if (!owner_lvl_s)                                state_d = RPT_IDLE;
                else if (cnt_q == CNT_W'(REPEAT_DELAY - 1))      state_d = RPT_RPT;
                else                                             state_d = RPT_DLY;
            end
            RPT_RPT: begin
                if (!owner_lvl_s) state_d = RPT_IDLE;
                else              state_d = RPT_RPT;
            end
            default: state_d = RPT_IDLE;
        endcase
    end

    // Repeat engine outputs: owner latch, counter and direction pulse.
    always_comb begin
        cnt_d       = {CNT_W{1'b0}};
        owner_d     = owner_q;
        dir_pulse_s = 4'b0000;
        case (state_q)
            RPT_IDLE: begin
                if (start_s) begin
                    owner_d     = dir_pick(dir_rise_s);
                    dir_pulse_s = 4'b0001 << owner_d;
                end else begin
                    owner_d = owner_q;
                end
            end
            RPT_DLY: begin
                if (!owner_lvl_s) begin
                    cnt_d = {CNT_W{1'b0}};
                end else if (cnt_q == CNT_W'(REPEAT_DELAY - 1)) begin
                    dir_pulse_s = 4'b0001 << owner_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RPT_RPT: begin
                if (!owner_lvl_s) begin
                    cnt_d = {CNT_W{1'b0}};
                end else if (cnt_q == CNT_W'(REPEAT_PERIOD - 1)) begin
                    dir_pulse_s = 4'b0001 << owner_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    assign cmd_d = {mode_d | run, zout_s, zin_s, dir_pulse_s};

    // State register and registered command bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RPT_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            owner_q <= 2'd0;
            mode_q  <= 1'b0;
            cmd_q   <= {CMD_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            mode_q  <= mode_d;
            cmd_q   <= cmd_d;
        end
    end

    assign win_ctrl_cmd = cmd_q;

endmodule
